// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter producing the mux select index. A grant is held for a
// whole (possibly multi-beat) transaction; o_select never leaves 0..NUM_INPUTS-1.
module rr_select_arbiter #(
    parameter int NUM_INPUTS = 4,
    localparam int SELECT_BITS = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_INPUTS-1:0]  i_req,
    input  logic [NUM_INPUTS-1:0]  i_last,
    input  logic                   i_ready,
    output logic [SELECT_BITS-1:0] o_select,
    output logic                   o_valid,
    output logic [NUM_INPUTS-1:0]  o_ack,
    output logic [0:0]             dbg_state,
    output logic [SELECT_BITS-1:0] dbg_ptr
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]             state;
    logic [SELECT_BITS-1:0] ptr;
    logic [SELECT_BITS-1:0] sel;

    function automatic logic [NUM_INPUTS-1:0] to_onehot(input logic [SELECT_BITS-1:0] idx);
        logic [NUM_INPUTS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (idx == SELECT_BITS'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    // Explicit wrap so non-power-of-2 sizes never produce an out-of-range index.
    function automatic logic [SELECT_BITS-1:0] wrap_inc(input logic [SELECT_BITS-1:0] x);
        return (x == SELECT_BITS'(NUM_INPUTS - 1)) ? '0 : x + 1'b1;
    endfunction

    logic [NUM_INPUTS-1:0]  sel_onehot;
    logic [SELECT_BITS-1:0] sel_next;
    logic                   req_cur;
    logic                   last_cur;
    logic                   accept;
    logic                   end_txn;
    logic [NUM_INPUTS-1:0]  cand;
    logic [SELECT_BITS-1:0] search_start;
    logic                   found;
    logic [SELECT_BITS-1:0] winner;

    assign sel_onehot = to_onehot(sel);
    assign sel_next   = wrap_inc(sel);
    assign req_cur    = |(i_req & sel_onehot);
    assign last_cur   = |(i_last & sel_onehot);

    // Handshake: a beat transfers on a cycle where o_valid && i_ready are both
    // high; o_ack tells the granted requester its beat was taken that cycle.
    assign o_valid  = (state == ST_GRANT) && req_cur && !i_rst;
    assign accept   = o_valid && i_ready;
    assign o_ack    = accept ? sel_onehot : '0;
    assign end_txn  = (state == ST_GRANT) && (!req_cur || (accept && last_cur));

    // In GRANT the finishing requester is masked and the scan starts just past it.
    assign cand         = (state == ST_GRANT) ? (i_req & ~sel_onehot) : i_req;
    assign search_start = (state == ST_GRANT) ? sel_next : ptr;

    always_comb begin
        logic [SELECT_BITS-1:0] idx;
        idx    = search_start;
        found  = 1'b0;
        winner = search_start;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!found && |(cand & to_onehot(idx))) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = wrap_inc(idx);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            sel   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state <= ST_GRANT;
                        sel   <= winner;
                    end
                end
                ST_GRANT: begin
                    if (end_txn) begin
                        ptr <= sel_next;
                        if (found) sel   <= winner;
                        else       state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_select  = sel;
    assign dbg_state = state;
    assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed bench for rr_select_arbiter with six requesters: a cycle table of
// inputs and hand-computed outputs, then a fairness/backpressure sequence.
module tb_rr_select_arbiter;

    localparam int N  = 6;
    localparam int SB = 3;

    logic          i_clk;
    logic          i_rst;
    logic [N-1:0]  i_req;
    logic [N-1:0]  i_last;
    logic          i_ready;
    logic [SB-1:0] o_select;
    logic          o_valid;
    logic [N-1:0]  o_ack;
    logic [0:0]    dbg_state;
    logic [SB-1:0] dbg_ptr;

    int checks;
    int failures;

    typedef struct {
        logic          rst;
        logic [N-1:0]  req;
        logic [N-1:0]  last;
        logic          ready;
        logic [SB-1:0] sel;
        logic          valid;
        logic [N-1:0]  ack;
        logic [0:0]    st;
        logic [SB-1:0] ptr;
    } vec_t;

    vec_t vecs[$];

    rr_select_arbiter #(.NUM_INPUTS(N)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_last(i_last),
        .i_ready(i_ready), .o_select(o_select), .o_valid(o_valid),
        .o_ack(o_ack), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [N-1:0] req, input logic [N-1:0] last,
                       input logic ready, input logic [SB-1:0] sel, input logic valid,
                       input logic [N-1:0] ack, input logic [0:0] st, input logic [SB-1:0] ptr);
        vec_t v;
        v.rst = rst; v.req = req; v.last = last; v.ready = ready;
        v.sel = sel; v.valid = valid; v.ack = ack; v.st = st; v.ptr = ptr;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [N-1:0] req, input logic [N-1:0] last, input logic ready);
        @(negedge i_clk);
        i_rst = rst; i_req = req; i_last = last; i_ready = ready;
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        i_rst = 1'b1; i_req = '0; i_last = '0; i_ready = 1'b0;
        repeat (2) @(posedge i_clk);

        //   rst req        last       rdy sel val ack        st ptr
        // reset held with all requesting, then first grant from 0
        add(1, 6'b111111, 6'b111111, 1, 0, 0, 6'b000000, 0, 0);
        add(1, 6'b111111, 6'b111111, 1, 0, 0, 6'b000000, 0, 0);
        add(0, 6'b111111, 6'b111111, 1, 0, 0, 6'b000000, 0, 0);
        // fairness and wrap, no bubbles
        add(0, 6'b111111, 6'b111111, 1, 0, 1, 6'b000001, 1, 0);
        add(0, 6'b111111, 6'b111111, 1, 1, 1, 6'b000010, 1, 1);
        add(0, 6'b111111, 6'b111111, 1, 2, 1, 6'b000100, 1, 2);
        add(0, 6'b111111, 6'b111111, 1, 3, 1, 6'b001000, 1, 3);
        add(0, 6'b111111, 6'b111111, 1, 4, 1, 6'b010000, 1, 4);
        add(0, 6'b111111, 6'b111111, 1, 5, 1, 6'b100000, 1, 5);
        add(0, 6'b111111, 6'b111111, 1, 0, 1, 6'b000001, 1, 0);
        add(0, 6'b111111, 6'b111111, 1, 1, 1, 6'b000010, 1, 1);
        // all drop: grant on 2 aborts, back to idle with ptr 3
        add(0, 6'b000000, 6'b000000, 1, 2, 0, 6'b000000, 1, 2);
        add(0, 6'b000000, 6'b000000, 1, 2, 0, 6'b000000, 0, 3);
        // single requester 2, then one-cycle idle bubble before re-grant
        add(0, 6'b000100, 6'b000100, 1, 2, 0, 6'b000000, 0, 3);
        add(0, 6'b000100, 6'b000100, 1, 2, 1, 6'b000100, 1, 3);
        add(0, 6'b000100, 6'b000100, 1, 2, 0, 6'b000000, 0, 3);
        add(0, 6'b000000, 6'b000000, 1, 2, 0, 6'b000000, 1, 3);
        // backpressure on requester 3
        add(0, 6'b001000, 6'b001000, 0, 2, 0, 6'b000000, 0, 3);
        add(0, 6'b001000, 6'b001000, 0, 3, 1, 6'b000000, 1, 3);
        add(0, 6'b001000, 6'b001000, 0, 3, 1, 6'b000000, 1, 3);
        add(0, 6'b001000, 6'b001000, 0, 3, 1, 6'b000000, 1, 3);
        add(0, 6'b001000, 6'b001000, 1, 3, 1, 6'b001000, 1, 3);
        // multi-beat lock on 4 with 1 pending, handoff searches 5,0,1
        add(0, 6'b010010, 6'b000000, 1, 3, 0, 6'b000000, 0, 4);
        add(0, 6'b010010, 6'b000000, 1, 4, 1, 6'b010000, 1, 4);
        add(0, 6'b010010, 6'b000000, 1, 4, 1, 6'b010000, 1, 4);
        add(0, 6'b010010, 6'b010000, 1, 4, 1, 6'b010000, 1, 4);
        add(0, 6'b000010, 6'b000000, 1, 1, 1, 6'b000010, 1, 5);
        // reset during a locked grant
        add(1, 6'b000010, 6'b000000, 1, 1, 0, 6'b000000, 1, 5);
        add(0, 6'b000100, 6'b000100, 1, 0, 0, 6'b000000, 0, 0);
        // abort by requester 2 while 5 is pending
        add(0, 6'b100100, 6'b000000, 1, 2, 1, 6'b000100, 1, 0);
        add(0, 6'b100000, 6'b000000, 1, 2, 0, 6'b000000, 1, 0);
        add(0, 6'b100000, 6'b100000, 1, 5, 1, 6'b100000, 1, 3);
        add(0, 6'b000000, 6'b000000, 1, 5, 0, 6'b000000, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].last, vecs[i].ready);
            chk("select", i, 32'(o_select),  32'(vecs[i].sel));
            chk("valid",  i, 32'(o_valid),   32'(vecs[i].valid));
            chk("ack",    i, 32'(o_ack),     32'(vecs[i].ack));
            chk("state",  i, 32'(dbg_state), 32'(vecs[i].st));
            chk("ptr",    i, 32'(dbg_ptr),   32'(vecs[i].ptr));
        end

        // Sequence: all six request single beats under a ready pattern; from
        // IDLE with ptr=0 the grant must rotate 0..5 and advance only on ready.
        begin
            logic [SB-1:0] exp_sel;
            logic          rdy;
            exp_sel = '0;
            drive(0, 6'b111111, 6'b111111, 1'b0);
            chk("seq_idle_valid", 100, 32'(o_valid), 32'd0);
            for (int k = 0; k < 24; k++) begin
                rdy = (k % 3) != 0;
                drive(0, 6'b111111, 6'b111111, rdy);
                chk("seq_select", 200 + k, 32'(o_select), 32'(exp_sel));
                chk("seq_range",  200 + k, 32'(o_select < SB'(N)), 32'd1);
                chk("seq_valid",  200 + k, 32'(o_valid), 32'd1);
                chk("seq_ack",    200 + k, 32'(o_ack), rdy ? (32'd1 << exp_sel) : 32'd0);
                if (rdy) exp_sel = (exp_sel == SB'(N - 1)) ? '0 : exp_sel + 1'b1;
            end
            // reset mid-stream: outputs drop at once, registered state on next edge
            drive(1, 6'b111111, 6'b000000, 1'b1);
            chk("seq_rst_valid", 300, 32'(o_valid), 32'd0);
            chk("seq_rst_ack",   300, 32'(o_ack),   32'd0);
            drive(0, 6'b000000, 6'b000000, 1'b1);
            chk("seq_post_rst_select", 301, 32'(o_select),  32'd0);
            chk("seq_post_rst_state",  301, 32'(dbg_state), 32'd0);
            chk("seq_post_rst_ptr",    301, 32'(dbg_ptr),   32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_select_arbiter.md
# rr_select_arbiter

Round-robin arbiter that generates the select index for the `mux` data-path block. Up to NUM_INPUTS requesters contend for a shared consumer. The arbiter grants one requester at a time and holds the grant for the whole transaction, possibly multi-beat. Its `o_select` drives the mux `i_select` directly, so it must never present an index ≥ NUM_INPUTS.

## Interface
- NUM_INPUTS, default 4: number of requesters and mux inputs; must be ≥ 1.
- SELECT_BITS, derived localparam, `max(1, $clog2(NUM_INPUTS))`: width of `o_select`, matching the mux select width.

Ports:
- i_clk   input   1   clock; all state updates on the rising edge.
- i_rst   input   1   reset; synchronous, active-high.
- i_req   input   NUM_INPUTS   per-requester request; held high until the requester's last beat is acked.
- i_last  input   NUM_INPUTS   per-requester flag: the current beat is the final beat of the transaction.
- i_ready input   1   downstream consumer accepts the beat on the mux output this cycle.
- o_select output SELECT_BITS   index of the granted requester; goes to the mux select.
- o_valid output  1   the mux output carries a valid beat.
- o_ack   output  NUM_INPUTS   one-hot; the beat of the indicated requester was accepted this cycle.

## Operation
- State: FSM {IDLE, GRANT}, registered `o_select`, and a round-robin pointer `ptr` (SELECT_BITS wide, range 0..NUM_INPUTS-1).
- Search: the winner is the first set bit of the candidate vector, scanning from `ptr` upward and wrapping modulo NUM_INPUTS.
- Wrap arithmetic: `x+1` equals NUM_INPUTS-1 → 0 explicitly. For non-power-of-2 NUM_INPUTS (e.g. 6), values 6 and 7 are never produced.
- IDLE:
  - If `i_req != 0`, go to GRANT with `o_select` = winner over `i_req`.
  - Otherwise stay in IDLE; `o_select` holds.
- GRANT:
  - `o_valid = i_req[o_select]` (combinational).
  - Accept condition: `o_valid && i_ready`. On accept, `o_ack = onehot(o_select)`; otherwise `o_ack = 0`.
  - Accept with `i_last[o_select]=0`: stay in GRANT; `o_select` unchanged (lock).
  - Accept with `i_last[o_select]=1`: transaction ends and `ptr` ← `o_select+1`. Candidates = `i_req` with bit `o_select` masked off, searched from the new ptr. If any candidate exists, stay in GRANT and load the new winner (no bubble). If none, go to IDLE.
  - No accept (`i_ready=0`): hold `o_select` and state.
  - Abort (`i_req[o_select]=0` while in GRANT): protocol violation tolerated. `o_valid=0`, and `ptr`/next-grant are handled exactly as for a last-beat accept, with no ack.
- `o_ack` and `o_valid` are 0 in IDLE.
- Reset mid-transaction: every state element returns to its reset value on the next edge. There is no partial ack.

## Timing
- Reset values: state IDLE, `ptr=0`, `o_select=0`, `o_valid=0`, `o_ack=0`.
- Grant latency from IDLE: a request sampled at edge N gives `o_valid=1` in cycle N+1.
- Back-to-back handoff: with `i_ready=1` and requests pending, consecutive single-beat transactions from different requesters issue on consecutive cycles. Throughput is 1 beat/cycle.
- A requester that just finished is masked for one cycle. If it is the only requester, there is a one-cycle IDLE bubble before it is re-granted.
- `o_select` changes only on a clock edge and is stable for the whole cycle. The mux output is therefore stable for the consumer.
- `o_ack` is combinational from `i_ready`. The requester samples it on the same edge as the consumer.

## Test plan
- Reset: assert i_rst for 2 cycles with `i_req=6'b111111` (NUM_INPUTS=6) → `o_valid=0`, `o_select=0`, `o_ack=0` throughout; first grant is `o_select=0` one cycle after release.
- Single requester: `i_req=6'b000100`, `i_last=6'b000100`, i_ready=1 → next cycle `o_select=2`, `o_valid=1`, `o_ack=6'b000100`; following cycle IDLE, `o_valid=0`; internal ptr=3.
- Fairness and wrap: all six requesting single-beat, `i_ready=1` always → `o_select` sequence 0,1,2,3,4,5,0,1 with no bubbles; `o_select` never 6 or 7.
- Backpressure: granted requester 3, i_ready=0 for 3 cycles → `o_select=3` and `o_valid=1` held, `o_ack=0`; on the fourth cycle i_ready=1 → `o_ack=6'b001000`.
- Multi-beat lock: requester 4 sends 3 beats (i_last on the third) while requester 1 is pending → `o_select=4` for all 3 accepts, then `o_select=1` on the next cycle (search 5,0,1).
- Abort and reset: requester 2 drops i_req mid-transaction → `o_valid=0`, no ack, grant moves to the next pending requester. Separately, i_rst during a locked grant → all outputs 0 on the next cycle.
